// File: rtl/dino_jump_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the dino vertical-motion engine.
// Geometry is in VGA pixels; velocities are px/frame, upward positive.
package dino_jump_ctrl_pkg;

    localparam int GROUND = 335;
    localparam int DINO_H = 60;

    localparam logic [9:0]        GROUND_Y     = 10'(GROUND - DINO_H);
    localparam logic [31:0]       DINO_X       = 32'd50;
    localparam logic signed [7:0] JUMP_V0      = 8'sd12;
    localparam logic signed [7:0] GRAVITY      = 8'sd1;
    localparam logic signed [7:0] FAST_GRAVITY = 8'sd3;
    localparam logic [9:0]        LAUNCH_Y     = GROUND_Y - 10'(JUMP_V0);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_AIR    = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    function automatic logic signed [10:0] sext_vel(input logic signed [7:0] v);
        return {{3{v[7]}}, v};
    endfunction

endpackage

// File: rtl/dino_jump_ctrl_rise_detect.sv
// Purpose: two-flop sampler plus AND-NOT edge detect on a slow frame clock.
// Latency: strobe is high for one clk, one edge after the input is first sampled high.
// Backpressure: none; free-running strobe.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic strobe
);

    logic q1;
    logic q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= d;
            q2 <= q1;
        end
    end

    assign strobe = q1 & ~q2;

endmodule

// File: rtl/dino_jump_ctrl.sv
// Purpose: per-frame jump/gravity physics turning up/down into the dino sprite position.
// Latency: dino_y moves two clk edges after frame_tick rises.
// Backpressure: none; game_over freezes all motion until reset.
import dino_jump_ctrl_pkg::*;

module dino_jump_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        up,
    input  logic        down,
    input  logic        game_over,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        airborne,
    output logic        ducking
);

    logic               strobe;
    state_t             state, state_n;
    logic [9:0]         y, y_n;
    logic signed [7:0]  vel, vel_n, g;
    logic signed [10:0] y_calc;
    logic               duck_n, air_n;

    rise_detect u_frame_edge (
        .clk    (clk),
        .reset  (reset),
        .d      (frame_tick),
        .strobe (strobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_GROUND;
            y        <= GROUND_Y;
            vel      <= '0;
            ducking  <= 1'b0;
            airborne <= 1'b0;
        end else begin
            state    <= state_n;
            y        <= y_n;
            vel      <= vel_n;
            ducking  <= duck_n;
            airborne <= air_n;
        end
    end

    // 11-bit signed so a fall past the ground or a climb above row 0 is visible before clamping
    always_comb begin
        state_n = state;
        y_n     = y;
        vel_n   = vel;
        duck_n  = ducking;
        air_n   = airborne;
        g       = down ? FAST_GRAVITY : GRAVITY;
        y_calc  = signed'({1'b0, y}) - sext_vel(vel);

        if (game_over) begin
            state_n = ST_HALT;
        end else begin
            case (state)
                ST_GROUND: begin
                    y_n = GROUND_Y;
                    if (strobe) begin
                        duck_n = down;
                        if (up) begin
                            y_n     = LAUNCH_Y;
                            vel_n   = JUMP_V0 - g;
                            state_n = ST_AIR;
                            air_n   = 1'b1;
                        end
                    end
                end
                ST_AIR: begin
                    if (strobe) begin
                        duck_n = 1'b0;
                        if (y_calc >= signed'({1'b0, GROUND_Y})) begin
                            y_n     = GROUND_Y;
                            vel_n   = '0;
                            state_n = ST_GROUND;
                            air_n   = 1'b0;
                        end else begin
                            y_n   = y_calc[10] ? 10'd0 : y_calc[9:0];
                            vel_n = vel - g;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dino_x = DINO_X;
    assign dino_y = {22'd0, y};

endmodule
